// File: rtl/brush_stamper_pkg.sv
// Shared types for the brush stamper: command opcodes, FSM states and the queued command record.
package paint_pkg;
    localparam int CMD_X_W     = 8;
    localparam int CMD_Y_W     = 8;
    localparam int CMD_COLOR_W = 3;
    localparam int CMD_SIZE_W  = 3;

    typedef enum logic [1:0] {OP_NOP, OP_PAINT, OP_ERASE, OP_CLEAR} op_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STAMP, S_DONE} stamp_state_t;

    typedef struct packed {
        op_t                    op;
        logic [CMD_X_W-1:0]     x;
        logic [CMD_Y_W-1:0]     y;
        logic [CMD_COLOR_W-1:0] color;
        logic [CMD_SIZE_W-1:0]  size;
    } cmd_t;
endpackage

// File: rtl/brush_stamper_if.sv
// Command and framebuffer-write bundle; master is the stamper side, slave the command/pixel-store side.
interface brush_stamper_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3,
    parameter int SIZE_W  = 3
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [COLOR_W-1:0] cmd_color;
    logic [SIZE_W-1:0]  cmd_size;
    logic               wr_en;
    logic               wr_ready;
    logic [X_W-1:0]     wr_x;
    logic [Y_W-1:0]     wr_y;
    logic [COLOR_W-1:0] wr_color;
    logic               busy;
    logic               done;

    modport master (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, cmd_size, wr_ready,
        output cmd_ready, wr_en, wr_x, wr_y, wr_color, busy, done
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, cmd_size, wr_ready,
        input  cmd_ready, wr_en, wr_x, wr_y, wr_color, busy, done
    );
endinterface

// File: rtl/brush_stamper_cmd_fifo.sv
// Synchronous command FIFO; head is read straight from the storage registers at the read pointer.
module cmd_fifo
    import paint_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = cmd_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/brush_stamper.sv
// Drawing engine: queues paint commands and expands each into a clipped square footprint or full clear.
module brush_stamper
    import paint_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int X_W        = 8,
    parameter int Y_W        = 8,
    parameter int COLOR_W    = 3,
    parameter int SIZE_W     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int BG_COLOR   = 0
) (
    input logic             clk,
    input logic             reset,
    brush_stamper_if.master bus
);
    localparam int XS_W = X_W + 2;
    localparam int YS_W = Y_W + 2;
    localparam logic signed [XS_W-1:0] XMAX = XS_W'(WIDTH - 1);
    localparam logic signed [YS_W-1:0] YMAX = YS_W'(HEIGHT - 1);

    stamp_state_t state, state_nx;
    cmd_t         fifo_in, head, cur;
    logic         full, empty, push, pop;

    logic signed [XS_W-1:0] xs, xe, x0s, x1s;
    logic signed [YS_W-1:0] ys, ye, y0s, y1s;
    logic [X_W-1:0]         x0, x1, cx, bx0, bx1;
    logic [Y_W-1:0]         y0, y1, cy, by1;
    logic [COLOR_W-1:0]     load_color, col;
    logic                   box_empty;

    assign bus.cmd_ready = !full && !reset;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign fifo_in       = '{op: op_t'(bus.cmd_op), x: bus.cmd_x, y: bus.cmd_y,
                             color: bus.cmd_color, size: bus.cmd_size};

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .T(cmd_t)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .din(fifo_in),
        .pop(pop), .head(head), .full(full), .empty(empty)
    );

    // Signed arithmetic so centres near or beyond an edge clip instead of wrapping.
    always_comb begin
        xs  = $signed({2'b00, cur.x}) - $signed(XS_W'(cur.size));
        xe  = $signed({2'b00, cur.x}) + $signed(XS_W'(cur.size));
        ys  = $signed({2'b00, cur.y}) - $signed(YS_W'(cur.size));
        ye  = $signed({2'b00, cur.y}) + $signed(YS_W'(cur.size));
        x0s = (xs < 0) ? '0 : xs;
        x1s = (xe > XMAX) ? XMAX : xe;
        y0s = (ys < 0) ? '0 : ys;
        y1s = (ye > YMAX) ? YMAX : ye;
        box_empty = (x0s > x1s) || (y0s > y1s);
        x0 = X_W'(x0s);
        x1 = X_W'(x1s);
        y0 = Y_W'(y0s);
        y1 = Y_W'(y1s);
        if (cur.op == OP_CLEAR) begin
            x0 = '0;
            x1 = X_W'(WIDTH - 1);
            y0 = '0;
            y1 = Y_W'(HEIGHT - 1);
            box_empty = 1'b0;
        end
        load_color = (cur.op == OP_PAINT) ? cur.color : COLOR_W'(BG_COLOR);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE:  if (!empty) begin
                         pop      = 1'b1;
                         state_nx = S_LOAD;
                     end
            S_LOAD:  state_nx = (cur.op == OP_NOP || box_empty) ? S_DONE : S_STAMP;
            S_STAMP: if (bus.wr_ready && cx == bx1 && cy == by1) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Row-major cursor; it only moves when the pixel store takes the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= '0;
            cx  <= '0;
            cy  <= '0;
            bx0 <= '0;
            bx1 <= '0;
            by1 <= '0;
            col <= '0;
        end else begin
            if (pop) cur <= head;
            if (state == S_LOAD) begin
                cx  <= x0;
                cy  <= y0;
                bx0 <= x0;
                bx1 <= x1;
                by1 <= y1;
                col <= load_color;
            end else if (state == S_STAMP && bus.wr_ready) begin
                if (cx == bx1) begin
                    cx <= bx0;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
        end
    end

    assign bus.wr_en    = (state == S_STAMP);
    assign bus.wr_x     = cx;
    assign bus.wr_y     = cy;
    assign bus.wr_color = col;
    assign bus.busy     = !empty || (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
endmodule
